exp_taylor_horner: RTL and testbench

// - Parametrised fixed-point e^x evaluator for the softmax datapath; successor to the fixed 3rd-order float exponential.
// - Order and format are set at elaboration. Uses a valid/ready handshake on both sides and saturating arithmetic with an overflow flag.
// - Evaluates one Horner step per clock: p=1; for k=ORDER..1: p = 1 + (x*p)/k.
// - Sits between the input stream and the softmax accumulator/normaliser.

---
 rtl/exp_taylor_horner_if.sv | 31 +++
 rtl/exp_taylor_horner.sv | 139 +++++++++++++
 tb/tb_exp_taylor_horner.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/exp_taylor_horner_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : exp_taylor_horner_if
// Brief    : Input/output stream handshake bundle for the e^x Horner evaluator.
// Revision : 1.0 - initial release
// ============================================================================
interface exp_taylor_horner_if #(
    parameter int DATALENGTH = 32,
    parameter int CNT_W      = 32
);
    logic                  InValid;
    logic                  InReady;
    logic [DATALENGTH-1:0] Datain;
    logic                  OutValid;
    logic                  OutReady;
    logic [DATALENGTH-1:0] DataOut;
    logic                  Ovf;
    logic [CNT_W-1:0]      SampleCount;

    modport slave (
        input  InValid, Datain, OutReady,
        output InReady, OutValid, DataOut, Ovf, SampleCount
    );

    modport master (
        output InValid, Datain, OutReady,
        input  InReady, OutValid, DataOut, Ovf, SampleCount
    );
endinterface
`default_nettype wire

// File: rtl/exp_taylor_horner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : exp_taylor_horner
// Brief    : Fixed-point e^x by Horner-evaluated Taylor series, one term/clock.
// Revision : 1.0 - initial release
// ============================================================================
module exp_taylor_horner #(
    parameter int DATALENGTH = 32,
    parameter int FRAC_W     = 16,
    parameter int ORDER      = 3,
    parameter int CNT_W      = 32
) (
    input  logic               Clock,
    input  logic               Reset,
    exp_taylor_horner_if.slave bus
);
    localparam int PW = 2 * DATALENGTH;
    localparam int KW = 4;

    localparam logic signed [DATALENGTH-1:0] ONE    = {{(DATALENGTH-1){1'b0}}, 1'b1} << FRAC_W;
    localparam logic signed [PW-1:0]         SAT_HI = {{(DATALENGTH+1){1'b0}}, {(DATALENGTH-1){1'b1}}};
    localparam logic signed [PW-1:0]         SAT_LO = {{(DATALENGTH+1){1'b1}}, {(DATALENGTH-1){1'b0}}};

    // Slot k holds round(2^FRAC_W / k); slot 0 is unused.
    function automatic logic [(ORDER+1)*DATALENGTH-1:0] build_recip();
        logic [(ORDER+1)*DATALENGTH-1:0] tbl;
        longint                          num;
        tbl = '0;
        for (int k = 1; k <= ORDER; k++) begin
            num = ((longint'(1) << FRAC_W) + longint'(k / 2)) / longint'(k);
            tbl[k*DATALENGTH +: DATALENGTH] = DATALENGTH'(num);
        end
        return tbl;
    endfunction

    localparam logic [(ORDER+1)*DATALENGTH-1:0] RECIP_TBL = build_recip();

    function automatic logic clips(input logic signed [PW-1:0] v);
        return (v > SAT_HI) || (v < SAT_LO);
    endfunction

    function automatic logic signed [DATALENGTH-1:0] sat(input logic signed [PW-1:0] v);
        if (v > SAT_HI) return SAT_HI[DATALENGTH-1:0];
        if (v < SAT_LO) return SAT_LO[DATALENGTH-1:0];
        return v[DATALENGTH-1:0];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic signed [DATALENGTH-1:0]   x_q, x_d;
    logic signed [DATALENGTH-1:0]   acc_q, acc_d;
    logic [KW-1:0]                  k_q, k_d;
    logic                           ovf_q, ovf_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    logic signed [DATALENGTH-1:0]   w_recip;
    logic signed [PW-1:0]           w_t_full, w_u_full, w_sum;
    logic signed [DATALENGTH-1:0]   w_t, w_u, w_acc_next;
    logic                           w_clip;

    // One Horner step: acc <- 1 + (x*acc)/k, each stage saturated.
    always_comb begin
        w_recip = '0;
        for (int i = 1; i <= ORDER; i++) begin
            if (k_q == KW'(i)) w_recip = RECIP_TBL[i*DATALENGTH +: DATALENGTH];
        end
        w_t_full   = (PW'(acc_q) * PW'(x_q)) >>> FRAC_W;
        w_t        = sat(w_t_full);
        w_u_full   = (PW'(w_t) * PW'(w_recip)) >>> FRAC_W;
        w_u        = sat(w_u_full);
        w_sum      = PW'(ONE) + PW'(w_u);
        w_acc_next = sat(w_sum);
        w_clip     = clips(w_t_full) | clips(w_u_full) | clips(w_sum);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        k_d     = k_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.InValid) begin
                    x_d     = $signed(bus.Datain);
                    acc_d   = ONE;
                    k_d     = KW'(ORDER);
                    ovf_d   = 1'b0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                acc_d = w_acc_next;
                ovf_d = ovf_q | w_clip;
                k_d   = k_q - KW'(1);
                if (k_q == KW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.OutReady) begin
                    state_d = S_IDLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.InReady     = (state_q == S_IDLE);
    assign bus.OutValid    = (state_q == S_DONE);
    assign bus.DataOut     = acc_q;
    assign bus.Ovf         = ovf_q;
    assign bus.SampleCount = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_exp_taylor_horner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_exp_taylor_horner
// Brief    : Directed bench for exp_taylor_horner at ORDER 3, 1 and 5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exp_taylor_horner;
    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [31:0] datain    = '0;
    logic        out_ready = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] d3, d1, d5;
    logic        o3, o1, o5;
    int          lat3, lat1, lat5;
    int          cnt3 = 0;
    int          cnt1 = 0;
    int          first_v, second_v;
    logic        seen;

    always #5 clk = ~clk;

    exp_taylor_horner_if #(.DATALENGTH(32), .CNT_W(32)) b3 ();
    exp_taylor_horner_if #(.DATALENGTH(32), .CNT_W(2))  b1 ();
    exp_taylor_horner_if #(.DATALENGTH(32), .CNT_W(32)) b5 ();

    assign b3.InValid = in_valid;  assign b3.Datain = datain;  assign b3.OutReady = out_ready;
    assign b1.InValid = in_valid;  assign b1.Datain = datain;  assign b1.OutReady = out_ready;
    assign b5.InValid = in_valid;  assign b5.Datain = datain;  assign b5.OutReady = out_ready;

    exp_taylor_horner #(.DATALENGTH(32), .FRAC_W(16), .ORDER(3), .CNT_W(32)) u_dut3 (
        .Clock(clk), .Reset(rst_n), .bus(b3));
    exp_taylor_horner #(.DATALENGTH(32), .FRAC_W(16), .ORDER(1), .CNT_W(2)) u_dut1 (
        .Clock(clk), .Reset(rst_n), .bus(b1));
    exp_taylor_horner #(.DATALENGTH(32), .FRAC_W(16), .ORDER(5), .CNT_W(32)) u_dut5 (
        .Clock(clk), .Reset(rst_n), .bus(b5));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic accept(input logic [31:0] x);
        in_valid = 1'b1;
        datain   = x;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Latency counts clocks from the accept edge; 0 means it never arrived.
    task automatic collect();
        lat3 = 0; lat1 = 0; lat5 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (b3.OutValid && lat3 == 0) begin lat3 = c; d3 = b3.DataOut; o3 = b3.Ovf; end
            if (b1.OutValid && lat1 == 0) begin lat1 = c; d1 = b1.DataOut; o1 = b1.Ovf; end
            if (b5.OutValid && lat5 == 0) begin lat5 = c; d5 = b5.DataOut; o5 = b5.Ovf; end
            if (lat3 != 0 && lat1 != 0 && lat5 != 0) break;
            @(negedge clk);
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        cnt3++;
        cnt1 = (cnt1 + 1) % 4;
    endtask

    task automatic xfer(input logic [31:0] x);
        accept(x);
        collect();
        handoff();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("rst_inready",  b3.InReady,     1);
        chk("rst_outvalid", b3.OutValid,    0);
        chk("rst_dataout",  b3.DataOut,     0);
        chk("rst_ovf",      b3.Ovf,         0);
        chk("rst_count",    b3.SampleCount, 0);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(32'h0000_0000);
        chk("zero_latency", lat3, 4);
        chk("zero_data",    d3,   32'h0001_0000);
        chk("zero_ovf",     o3,   0);
        chk("zero_count",   b3.SampleCount, cnt3);

        xfer(32'h0001_0000);
        chk("one_data",  d3, 32'h0002_AAAA);
        chk("one_ovf",   o3, 0);
        chk("one_o1",    d1, 32'h0002_0000);
        xfer(32'hFFFF_0000);
        chk("mone_data", d3, 32'h0000_5556);
        chk("mone_ovf",  o3, 0);
        chk("mone_o1",   d1, 32'h0000_0000);
        xfer(32'hFFFE_0000);
        chk("mtwo_neg_o3", d3, 32'hFFFF_AAAC);
        chk("mtwo_neg_o1", d1, 32'hFFFF_0000);

        xfer(32'h7FFF_0000);
        chk("big_data",   d3, 32'h7FFF_FFFF);
        chk("big_ovf",    o3, 1);
        chk("big_o1",     d1, 32'h7FFF_FFFF);
        chk("big_o1_ovf", o1, 1);
        xfer(32'h0000_0000);
        chk("after_big_ovf",  o3, 0);
        chk("after_big_data", d3, 32'h0001_0000);

        // Consumer stalls while a new sample waits at the input.
        in_valid = 1'b1;
        datain   = 32'h0001_0000;
        @(negedge clk);
        datain   = 32'h0000_0000;
        collect();
        chk("stall_first", d3, 32'h0002_AAAA);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_dataout",  b3.DataOut,  32'h0002_AAAA);
            chk("stall_outvalid", b3.OutValid, 1);
            chk("stall_inready",  b3.InReady,  0);
        end
        handoff();
        chk("stall_release_count",   b3.SampleCount, cnt3);
        chk("stall_release_inready", b3.InReady,     1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_next_accepted", b3.InReady, 0);
        collect();
        chk("stall_next_data", d3, 32'h0001_0000);
        handoff();
        chk("stall_next_count", b3.SampleCount, cnt3);

        in_valid  = 1'b1;
        datain    = 32'h0000_0000;
        out_ready = 1'b1;
        first_v   = 0;
        second_v  = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (b3.OutValid) begin
                if (first_v == 0) first_v = c;
                else if (second_v == 0) second_v = c;
            end
        end
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
        chk("init_interval", second_v - first_v, 5);

        // Reset pulse in the middle of an iteration.
        accept(32'h0001_0000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_outvalid", b3.OutValid,    0);
        chk("midrst_dataout",  b3.DataOut,     0);
        chk("midrst_ovf",      b3.Ovf,         0);
        chk("midrst_count",    b3.SampleCount, 0);
        chk("midrst_inready",  b3.InReady,     1);
        @(negedge clk);
        rst_n = 1'b1;
        cnt3  = 0;
        cnt1  = 0;
        seen  = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | b3.OutValid;
        end
        chk("midrst_no_output", seen, 0);

        xfer(32'h0001_0000);
        chk("post_rst_data", d3,   32'h0002_AAAA);
        chk("ord1_latency",  lat1, 2);
        chk("ord1_data",     d1,   32'h0002_0000);
        chk("ord5_latency",  lat5, 6);
        chk("ord5_near_e",   (d5 >= 32'h0002_B775) && (d5 <= 32'h0002_B779), 1);
        repeat (4) xfer(32'h0000_0000);
        chk("cnt2_wrap",  b1.SampleCount, cnt1);
        chk("cnt32_five", b3.SampleCount, cnt3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
